// File: rtl/sram_arbiter.sv
// Two-port (data / instruction) arbiter in front of a 16-bit asynchronous SRAM.
// Each 32-bit word is moved as two halfword phases; ports are served round-robin.
module sram_arbiter #(
    parameter int unsigned SRAM_WAIT = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_rd_en,
    input  logic        d_wr_en,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_freeze,
    input  logic        i_rd_en,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(SRAM_WAIT - 32'd1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        rr_instr_q;      // 1: instruction port has priority on contention
    logic        gnt_instr_q;
    logic        wr_q;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic [15:0] lo_buf_q;
    logic [31:0] d_rdata_q;
    logic [31:0] i_rdata_q;
    logic        d_ready_q;
    logic        i_ready_q;
    logic [17:0] sram_addr_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        bytes_n_q;
    logic        dq_oe_q;
    logic [15:0] dq_out_q;

    logic        d_req_s;
    logic        i_req_s;
    logic        gnt_instr_d;
    logic        wr_d;
    logic [31:0] req_addr_s;
    logic [16:0] word_d;
    logic        phase_last_s;

    // Grant decision and request decode, only consumed while idle.
    always_comb begin
        d_req_s      = d_rd_en | d_wr_en;
        i_req_s      = i_rd_en;
        gnt_instr_d  = i_req_s & (~d_req_s | rr_instr_q);
        wr_d         = ~gnt_instr_d & d_wr_en;
        req_addr_s   = gnt_instr_d ? i_addr : d_addr;
        word_d       = 17'((req_addr_s - BASE_ADDR) >> 2);
        phase_last_s = (cnt_q == WAIT_LAST);
    end

    // Transfer FSM with all SRAM-facing and port-facing outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rr_instr_q  <= 1'b0;
            gnt_instr_q <= 1'b0;
            wr_q        <= 1'b0;
            word_q      <= 17'd0;
            wdata_q     <= 32'd0;
            lo_buf_q    <= 16'd0;
            d_rdata_q   <= 32'd0;
            i_rdata_q   <= 32'd0;
            d_ready_q   <= 1'b0;
            i_ready_q   <= 1'b0;
            sram_addr_q <= 18'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bytes_n_q   <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= 16'd0;
        end else begin
            d_ready_q <= 1'b0;
            i_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (d_req_s | i_req_s) begin
                        state_q     <= ST_LO;
                        cnt_q       <= 4'd0;
                        rr_instr_q  <= ~gnt_instr_d;
                        gnt_instr_q <= gnt_instr_d;
                        wr_q        <= wr_d;
                        word_q      <= word_d;
                        wdata_q     <= d_wdata;
                        sram_addr_q <= {word_d, 1'b0};
                        ce_n_q      <= 1'b0;
                        bytes_n_q   <= 1'b0;
                        oe_n_q      <= wr_d;
                        we_n_q      <= ~wr_d;
                        dq_oe_q     <= wr_d;
                        dq_out_q    <= d_wdata[15:0];
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LO: begin
                    if (phase_last_s) begin
                        state_q     <= ST_HI;
                        cnt_q       <= 4'd0;
                        lo_buf_q    <= SRAM_DQ;
                        sram_addr_q <= {word_q, 1'b1};
                        dq_out_q    <= wdata_q[31:16];
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_HI: begin
                    if (phase_last_s) begin
                        state_q     <= ST_DONE;
                        cnt_q       <= 4'd0;
                        d_ready_q   <= ~gnt_instr_q;
                        i_ready_q   <= gnt_instr_q;
                        sram_addr_q <= 18'd0;
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        bytes_n_q   <= 1'b1;
                        dq_oe_q     <= 1'b0;
                        // Writes never disturb the data port's last read value.
                        if (!wr_q) begin
                            if (gnt_instr_q) begin
                                i_rdata_q <= {SRAM_DQ, lo_buf_q};
                            end else begin
                                d_rdata_q <= {SRAM_DQ, lo_buf_q};
                            end
                        end else begin
                            d_rdata_q <= d_rdata_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sram_addr_q <= 18'd0;
                    ce_n_q      <= 1'b1;
                    oe_n_q      <= 1'b1;
                    we_n_q      <= 1'b1;
                    bytes_n_q   <= 1'b1;
                    dq_oe_q     <= 1'b0;
                end
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = bytes_n_q;
    assign SRAM_LB_N = bytes_n_q;
    assign d_rdata   = d_rdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_ready   = d_ready_q;
    assign i_ready   = i_ready_q;
    assign d_freeze  = (d_rd_en | d_wr_en) & ~d_ready_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 256K x 16 SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_rd_en, d_wr_en, i_rd_en;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic [31:0] d_rdata, i_rdata;
    logic        d_ready, i_ready, d_freeze;
    wire  [15:0] sram_dq;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

    logic [15:0] mem [0:262143];

    int total = 0;
    int bad   = 0;
    int lat, we_cnt, oe_cnt, act_cnt, frz_bad, wrong_rdy;
    logic frz_at_rdy;
    int rdy_pos [0:3];
    logic rdy_instr [0:3];
    int n_rdy, both_rdy;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_freeze(d_freeze),
        .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    always #5 clk = ~clk;

    assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N && !SRAM_UB_N && !SRAM_LB_N)
            mem[SRAM_ADDR] <= sram_dq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the expected port's ready, tallying bus activity on the way.
    task automatic wait_ready(input bit exp_i);
        lat = 99; we_cnt = 0; oe_cnt = 0; act_cnt = 0; frz_bad = 0; wrong_rdy = 0;
        frz_at_rdy = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (!SRAM_WE_N) we_cnt++;
            if (!SRAM_OE_N) oe_cnt++;
            if (!SRAM_CE_N && !SRAM_UB_N && !SRAM_LB_N) act_cnt++;
            if (exp_i ? d_ready : i_ready) wrong_rdy++;
            if (exp_i ? i_ready : d_ready) begin
                lat = n;
                frz_at_rdy = d_freeze;
                break;
            end
            if (d_freeze !== (d_rd_en | d_wr_en)) frz_bad++;
        end
    endtask

    task automatic drop_and_check_pulse(input string tag);
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        @(negedge clk);
        chk(tag, {30'd0, d_ready, i_ready}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        d_rd_en = 1'b0; d_wr_en = 1'b0; i_rd_en = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; i_addr = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_ready",   {30'd0, d_ready, i_ready}, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_ctrl", {27'd0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);

        // Word write of 0xDEADBEEF to the first SRAM word.
        rst = 1'b0;
        d_wr_en = 1'b1; d_addr = 32'd1024; d_wdata = 32'hDEADBEEF;
        wait_ready(1'b0);
        chk("wr_latency", 32'(lat), 32'd5);
        chk("wr_we_cycles", 32'(we_cnt), 32'd4);
        chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        chk("wr_active_cycles", 32'(act_cnt), 32'd4);
        chk("wr_freeze", 32'(frz_bad), 32'd0);
        chk("wr_freeze_at_rdy", 32'(frz_at_rdy), 32'd0);
        chk("wr_d_rdata_kept", d_rdata, 32'd0);
        chk("wr_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("wr_mem1", 32'(mem[1]), 32'h0000DEAD);
        drop_and_check_pulse("wr_pulse_one_cycle");

        // Read the word back through the data port.
        d_rd_en = 1'b1; d_addr = 32'd1024;
        wait_ready(1'b0);
        chk("rd_latency", 32'(lat), 32'd5);
        chk("rd_oe_cycles", 32'(oe_cnt), 32'd4);
        chk("rd_we_cycles", 32'(we_cnt), 32'd0);
        chk("rd_freeze", 32'(frz_bad), 32'd0);
        chk("rd_freeze_at_rdy", 32'(frz_at_rdy), 32'd0);
        chk("rd_wrong_port", 32'(wrong_rdy), 32'd0);
        chk("rd_d_rdata", d_rdata, 32'hDEADBEEF);
        drop_and_check_pulse("rd_pulse_one_cycle");
        chk("rd_d_rdata_hold", d_rdata, 32'hDEADBEEF);

        // Read and write enables together behave as a write.
        d_rd_en = 1'b1; d_wr_en = 1'b1; d_addr = 32'd1032; d_wdata = 32'h12345678;
        wait_ready(1'b0);
        chk("rw_latency", 32'(lat), 32'd5);
        chk("rw_we_cycles", 32'(we_cnt), 32'd4);
        chk("rw_d_rdata_kept", d_rdata, 32'hDEADBEEF);
        chk("rw_mem4", 32'(mem[4]), 32'h00005678);
        chk("rw_mem5", 32'(mem[5]), 32'h00001234);
        drop_and_check_pulse("rw_pulse_one_cycle");

        // Preload word at 1028, then fetch it through the instruction port.
        d_wr_en = 1'b1; d_addr = 32'd1028; d_wdata = 32'h22221111;
        wait_ready(1'b0);
        chk("pre_mem2", 32'(mem[2]), 32'h00001111);
        chk("pre_mem3", 32'(mem[3]), 32'h00002222);
        drop_and_check_pulse("pre_pulse_one_cycle");
        i_rd_en = 1'b1; i_addr = 32'd1028;
        wait_ready(1'b1);
        chk("if_latency", 32'(lat), 32'd5);
        chk("if_d_ready_quiet", 32'(wrong_rdy), 32'd0);
        chk("if_i_rdata", i_rdata, 32'h22221111);
        chk("if_d_rdata_kept", d_rdata, 32'hDEADBEEF);
        drop_and_check_pulse("if_pulse_one_cycle");

        // Contention held from reset: grants alternate D, I, D, I.
        rst = 1'b1;
        d_rd_en = 1'b1; d_addr = 32'd1024; i_rd_en = 1'b1; i_addr = 32'd1028;
        @(negedge clk);
        chk("rst2_rdata", d_rdata | i_rdata, 32'd0);
        rst = 1'b0;
        n_rdy = 0; both_rdy = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (d_ready && i_ready) both_rdy++;
            if ((d_ready || i_ready) && n_rdy < 4) begin
                rdy_pos[n_rdy]   = n;
                rdy_instr[n_rdy] = i_ready;
                if (i_ready) chk("rr_i_rdata", i_rdata, 32'h22221111);
                else         chk("rr_d_rdata", d_rdata, 32'hDEADBEEF);
                n_rdy++;
            end
        end
        chk("rr_count", 32'(n_rdy), 32'd4);
        chk("rr_both", 32'(both_rdy), 32'd0);
        chk("rr_order", {28'd0, rdy_instr[0], rdy_instr[1], rdy_instr[2], rdy_instr[3]}, 32'h5);
        chk("rr_pos0", 32'(rdy_pos[0]), 32'd5);
        chk("rr_pos1", 32'(rdy_pos[1]), 32'd11);
        chk("rr_pos2", 32'(rdy_pos[2]), 32'd17);
        chk("rr_pos3", 32'(rdy_pos[3]), 32'd23);
        drop_and_check_pulse("rr_pulse_one_cycle");

        // Reset during the high phase of a write aborts it silently.
        d_wr_en = 1'b1; d_addr = 32'd1040; d_wdata = 32'hAAAA5555;
        repeat (3) @(negedge clk);
        chk("ab_in_hi_addr", 32'(SRAM_ADDR), 32'd9);
        chk("ab_in_hi_we", 32'(SRAM_WE_N), 32'd0);
        rst = 1'b1; d_wr_en = 1'b0;
        @(negedge clk);
        chk("ab_ctrl", {27'd0, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
        chk("ab_addr", 32'(SRAM_ADDR), 32'd0);
        chk("ab_no_ready", {30'd0, d_ready, i_ready}, 32'd0);
        chk("ab_mem8", 32'(mem[8]), 32'h00005555);
        chk("ab_d_rdata_clr", d_rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_quiet", {30'd0, d_ready, i_ready}, 32'd0);
        d_rd_en = 1'b1; d_addr = 32'd1024; i_rd_en = 1'b1; i_addr = 32'd1028;
        wait_ready(1'b0);
        chk("ab_d_wins", 32'(lat), 32'd5);
        chk("ab_i_quiet", 32'(wrong_rdy), 32'd0);
        chk("ab_d_rdata", d_rdata, 32'hDEADBEEF);
        drop_and_check_pulse("ab_pulse_one_cycle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter SRAM_WAIT, default 2: cycles each 16-bit SRAM halfword access is held (legal range 1..15).
REQ-002 Parameter BASE_ADDR, default 1024: byte address subtracted from both ports' addresses before SRAM mapping.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 d_rd_en  input  1  data-port read request (MEM stage).
REQ-006 d_wr_en  input  1  data-port write request (MEM stage).
REQ-007 d_addr  input  32  data-port byte address, word aligned.
REQ-008 d_wdata  input  32  data-port write data.
REQ-009 d_rdata  output  32  data-port read data, valid when d_ready=1.
REQ-010 d_ready  output  1  one-cycle completion pulse for the data port.
REQ-011 d_freeze  output  1  pipeline stall = (d_rd_en|d_wr_en) & ~d_ready, combinational.
REQ-012 i_rd_en  input  1  instruction-port read request.
REQ-013 i_addr  input  32  instruction-port byte address, word aligned.
REQ-014 i_rdata  output  32  instruction read data, valid when i_ready=1.
REQ-015 i_ready  output  1  one-cycle completion pulse for the instruction port.
REQ-016 SRAM_DQ  inout  16  SRAM data bus.
REQ-017 SRAM_ADDR  output  18  SRAM halfword address.
REQ-018 SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM controls.

Function
REQ-019 FSM states IDLE, LO, HI, DONE; IDLE -> LO on grant; LO -> HI after SRAM_WAIT cycles; HI -> DONE after SRAM_WAIT cycles; DONE -> IDLE unconditionally.
REQ-020 Arbitration occurs only in IDLE; with one requester pending, that requester is granted.
REQ-021 With both pending, round-robin: the port not granted most recently wins; pointer updates on every grant; after reset the data port has priority.
REQ-022 Grant, operation type, address and write data are latched at grant; requester input changes after grant do not affect the transfer in progress.
REQ-023 d_rd_en and d_wr_en both high is treated as a write.
REQ-024 Word index W = (addr - BASE_ADDR)[18:2]; LO accesses SRAM_ADDR = {W,1'b0} carrying bits [15:0]; HI accesses {W,1'b1} carrying bits [31:16].
REQ-025 In LO/HI: CE_N=0, UB_N=0, LB_N=0; a read drives OE_N=0, WE_N=1 and DQ high-Z; a write drives OE_N=1, WE_N=0 and DQ with the halfword.
REQ-026 In IDLE/DONE: CE_N=WE_N=OE_N=UB_N=LB_N=1, DQ high-Z, SRAM_ADDR=0.
REQ-027 Read data is sampled from SRAM_DQ on the last cycle of each halfword phase and assembled into the granted port's rdata register.
REQ-028 The granted port's ready is 1 only in DONE; the other port's ready stays 0; latency from the grant cycle to ready = 2*SRAM_WAIT+1 cycles (5 at default).
REQ-029 d_rdata/i_rdata hold their last value until overwritten by a later read on the same port; writes leave d_rdata unchanged.
REQ-030 A request still asserted in the cycle after DONE is a new request and is re-arbitrated in IDLE.
REQ-031 Back-to-back grants: minimum IDLE dwell of 1 cycle between DONE and the next LO.

Reset
REQ-032 While rst=1 at a clock edge: FSM -> IDLE, RR pointer -> data port, d_ready=i_ready=0, d_rdata=i_rdata=0, SRAM outputs per REQ-026.
REQ-033 Reset mid-transfer aborts it with no ready pulse; a partially written word is left as-is in SRAM.

Verification
REQ-034 d_wr_en=1, d_addr=1024, d_wdata=0xDEADBEEF -> SRAM_ADDR 0 gets 0xBEEF, address 1 gets 0xDEAD, WE_N low for 4 cycles, d_ready pulses 5 cycles after grant.
REQ-035 Then d_rd_en=1, d_addr=1024 -> d_rdata=0xDEADBEEF on the d_ready cycle; d_freeze=1 every cycle before it and 0 on it.
REQ-036 d_rd_en and i_rd_en asserted together from reset and held -> grant order D, I, D, I; each ready pulses only for its own port.
REQ-037 i_rd_en=1, i_addr=1028 with SRAM[2]=0x1111, SRAM[3]=0x2222 -> i_rdata=0x22221111, d_ready stays 0.
REQ-038 rst pulsed during HI of a write -> next cycle all SRAM controls high, DQ high-Z, no ready pulse, and data port wins the next contention.
REQ-039 d_rd_en and d_wr_en both high, d_wdata=0x12345678 -> a write is performed; d_rdata is unchanged.
